// File: rtl/rmgmt_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory bus between the base pipeline and the RISC-MGMT extension.
// Optional ext misalignment trap is enabled with `RMGMT_MEM_ALIGN_CHECK_EN.
module rmgmt_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  core_ren,
    input  logic                  core_wen,
    input  logic [ADDR_W-1:0]     core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [DATA_W/8-1:0]   core_byte_en,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_busy,
    input  logic                  ext_ren,
    input  logic                  ext_wen,
    input  logic [ADDR_W-1:0]     ext_addr,
    input  logic [DATA_W-1:0]     ext_store,
    input  logic [DATA_W/8-1:0]   ext_byte_en,
    output logic [DATA_W-1:0]     ext_load,
    output logic                  ext_busy,
    output logic                  ext_fault,
    output logic                  bus_ren,
    output logic                  bus_wen,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_byte_en,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        EXT  = 2'd2
    } state_t;

    state_t              state_reg;
    logic                last_ext_reg;
    logic [DATA_W-1:0]   core_load_reg;
    logic [DATA_W-1:0]   ext_load_reg;

    logic core_pending;
    logic ext_raw;
    logic ext_pending;
    logic ext_misaligned;
    logic core_done;
    logic ext_done;
    logic core_capture;
    logic ext_capture;
    logic grant_core;
    logic grant_ext;

    assign core_pending = core_ren | core_wen;
    assign ext_raw      = ext_ren | ext_wen;

`ifdef RMGMT_MEM_ALIGN_CHECK_EN
    assign ext_misaligned = ((ext_byte_en == 4'b1111) && (ext_addr[1:0] != 2'b00)) ||
                            (((ext_byte_en == 4'b0011) || (ext_byte_en == 4'b1100)) && ext_addr[0]);
    assign ext_fault = nRST & (state_reg == IDLE) & ext_raw & ext_misaligned;
`else
    assign ext_misaligned = 1'b0;
    assign ext_fault      = 1'b0;
`endif

    // A misaligned ext request never competes for the bus.
    assign ext_pending = ext_raw & ~ext_misaligned;

    assign grant_core = core_pending & (~ext_pending | last_ext_reg);
    assign grant_ext  = ext_pending & (~core_pending | ~last_ext_reg);

    assign core_done = (state_reg == CORE) & ~bus_busy;
    assign ext_done  = (state_reg == EXT) & ~bus_busy;

    // Load data is only delivered to a requester that is still waiting for it.
    assign core_capture = core_done & core_pending & bus_ren;
    assign ext_capture  = ext_done & ext_raw & bus_ren;

    assign core_busy = core_pending & ~core_done;
    assign ext_busy  = ext_raw & ~ext_done & ~ext_fault;

    assign core_rdata = core_capture ? bus_rdata : core_load_reg;
    assign ext_load   = ext_capture ? bus_rdata : ext_load_reg;

    // The bus_* outputs double as the request register: loaded on grant, cleared on completion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            last_ext_reg  <= 1'b1;
            core_load_reg <= '0;
            ext_load_reg  <= '0;
            bus_ren       <= 1'b0;
            bus_wen       <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_byte_en   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_core) begin
                        state_reg   <= CORE;
                        bus_ren     <= core_ren & ~core_wen;
                        bus_wen     <= core_wen;
                        bus_addr    <= core_addr;
                        bus_wdata   <= core_wdata;
                        bus_byte_en <= core_byte_en;
                    end else if (grant_ext) begin
                        state_reg   <= EXT;
                        bus_ren     <= ext_ren & ~ext_wen;
                        bus_wen     <= ext_wen;
                        bus_addr    <= ext_addr;
                        bus_wdata   <= ext_store;
                        bus_byte_en <= ext_byte_en;
                    end
                end
                CORE, EXT: begin
                    if (!bus_busy) begin
                        state_reg    <= IDLE;
                        last_ext_reg <= (state_reg == EXT);
                        bus_ren      <= 1'b0;
                        bus_wen      <= 1'b0;
                        bus_addr     <= '0;
                        bus_wdata    <= '0;
                        bus_byte_en  <= '0;
                        if (core_capture) begin
                            core_load_reg <= bus_rdata;
                        end
                        if (ext_capture) begin
                            ext_load_reg <= bus_rdata;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
